// File: rtl/diff_equation_mc.sv
// ---------------------------------------------------------------------------
// diff_equation_mc
//   Multi-channel linear difference equation engine:
//     y[n] = (sum_{k=0..N} bk*x[n-k] - sum_{k=1..N} ak*y[n-k]) >>> FRAC
//   One shared multiplier evaluates one term per cycle. All channels share a
//   single coefficient set; each channel keeps its own x/y history.
//
//   Configuration macro:
//     DIFF_EQUATION_MC_SATURATE_EN  defined   -> result clamps to DATA_W range
//                                   undefined -> result wraps (truncation)
//
//   Ports:
//     ACLK, ARESETN      clock, synchronous active-low reset
//     in_valid/in_ready  sample handshake; in_ch selects the channel,
//                        in_data carries x[n] (signed)
//     out_valid/out_ready result handshake; out_ch/out_data carry y[n]
//     coef_wr/coef_addr/coef_data  coefficient write (0..N -> b0..bN,
//                        N+1..2N -> a1..aN), accepted only while idle
//     hist_clr           clears all channel history, acts only while idle
//     busy               high whenever the FSM is not idle
//     dbg_state          current FSM state (0 IDLE, 1 MAC, 2 OUT)
//
//   Handshake rule: a transfer happens on a rising edge where valid && ready.
//   in_ready depends only on state; out_valid/out_ch/out_data stay constant
//   until the result is taken.
// ---------------------------------------------------------------------------
module diff_equation_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int FRAC     = 14,
    parameter int ORDER    = 2,
    parameter int CHANNELS = 2,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CA_W    = $clog2(2*ORDER+1)
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     coef_wr,
    input  logic [CA_W-1:0]          coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     hist_clr,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    localparam int NTERM  = 2*ORDER + 1;
    localparam int CNT_W  = $clog2(NTERM + 1);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTERM);
    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CHANNELS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [COEF_W-1:0] coef   [NTERM];
    logic signed [DATA_W-1:0] x_hist [CHANNELS][ORDER];
    logic signed [DATA_W-1:0] y_hist [CHANNELS][ORDER];

    logic signed [DATA_W-1:0] cur_x;
    logic [CH_W-1:0]          cur_ch;
    logic [CNT_W-1:0]         idx_q;
    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_sub_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic                     ch_ok;
    logic                     accept;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [DATA_W-1:0] operand;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] result;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign dbg_state = state_q;
    assign ch_ok     = ({1'b0, in_ch} < CH_LIM);
    assign accept    = in_valid && in_ready;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid && ch_ok) state_d = MAC;
            MAC:  if (idx_q == CNT_W'(NTERM)) state_d = OUT;
            OUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Term select: idx 0..N walks x[n]..x[n-N] with b0..bN, idx N+1..2N walks
    // y[n-1]..y[n-N] with a1..aN. At idx == NTERM no term is left, so the
    // coefficient defaults to zero and the product register drains to zero.
    always_comb begin
        operand  = cur_x;
        coef_sel = '0;
        for (int k = 0; k < NTERM; k++) begin
            if (idx_q == CNT_W'(k)) coef_sel = coef[k];
        end
        for (int k = 1; k <= ORDER; k++) begin
            if (idx_q == CNT_W'(k))       operand = x_hist[cur_ch][k-1];
            if (idx_q == CNT_W'(ORDER+k)) operand = y_hist[cur_ch][k-1];
        end
    end

    assign prod_d = PROD_W'(coef_sel) * PROD_W'(operand);

    // Product is registered one cycle ahead of the accumulate, so the last
    // term is folded in on the cycle that also produces the result.
    assign sum     = prod_sub_q ? (acc_q - ACC_W'(prod_q)) : (acc_q + ACC_W'(prod_q));
    assign shifted = sum >>> FRAC;

`ifdef DIFF_EQUATION_MC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    always_comb begin
        result = DATA_W'(shifted);
        if (shifted > SAT_MAX)      result = {1'b0, {(DATA_W-1){1'b1}}};
        else if (shifted < SAT_MIN) result = {1'b1, {(DATA_W-1){1'b0}}};
    end
`else
    assign result = DATA_W'(shifted);
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int k = 0; k < NTERM; k++) coef[k] <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    x_hist[c][k] <= '0;
                    y_hist[c][k] <= '0;
                end
            end
            cur_x      <= '0;
            cur_ch     <= '0;
            idx_q      <= '0;
            prod_q     <= '0;
            prod_sub_q <= 1'b0;
            acc_q      <= '0;
            out_ch     <= '0;
            out_data   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Written on the accept edge, so a coincident write is
                    // already visible when the MAC reads it next cycle.
                    if (coef_wr && (coef_addr <= CA_W'(2*ORDER)))
                        coef[coef_addr] <= coef_data;
                    if (hist_clr) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            for (int k = 0; k < ORDER; k++) begin
                                x_hist[c][k] <= '0;
                                y_hist[c][k] <= '0;
                            end
                        end
                    end
                    // Out-of-range channels are taken and dropped here.
                    if (accept && ch_ok) begin
                        cur_x      <= in_data;
                        cur_ch     <= in_ch;
                        idx_q      <= '0;
                        prod_q     <= '0;
                        prod_sub_q <= 1'b0;
                        acc_q      <= '0;
                    end
                end
                MAC: begin
                    idx_q      <= idx_q + 1'b1;
                    acc_q      <= sum;
                    prod_q     <= prod_d;
                    prod_sub_q <= (idx_q > CNT_W'(ORDER));
                    if (idx_q == CNT_W'(NTERM)) begin
                        out_data <= result;
                        out_ch   <= cur_ch;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        for (int k = ORDER-1; k >= 1; k--) begin
                            x_hist[cur_ch][k] <= x_hist[cur_ch][k-1];
                            y_hist[cur_ch][k] <= y_hist[cur_ch][k-1];
                        end
                        x_hist[cur_ch][0] <= cur_x;
                        y_hist[cur_ch][0] <= out_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/diff_equation_mc.md
DIFF_EQUATION_MC -- requirements
Module: diff_equation_mc

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_W, 16, signed sample and result width.
  COEF_W, 16, signed coefficient width.
  FRAC, 14, coefficient fractional bits (1.0 = 2^FRAC).
  ORDER, 2, equation order N (1..8).
  CHANNELS, 2, independent channels sharing one coefficient set (1..16).
REQ-002 Ports (name, direction, width, meaning), one per line:
  ACLK  in  1  clock; all logic on the rising edge.
  ARESETN  in  1  reset; synchronous and active-low.
  in_valid  in  1  sample offered.
  in_ready  out  1  sample accepted when in_valid && in_ready.
  in_ch  in  clog2(CHANNELS), minimum 1  channel index of the sample.
  in_data  in  DATA_W  x[n], signed.
  out_valid  out  1  result available.
  out_ready  in  1  result consumed when out_valid && out_ready.
  out_ch  out  clog2(CHANNELS), minimum 1  channel of the result.
  out_data  out  DATA_W  y[n], signed.
  coef_wr  in  1  coefficient write strobe.
  coef_addr  in  clog2(2*ORDER+1)  0..ORDER selects b0..bN; ORDER+1..2*ORDER selects a1..aN.
  coef_data  in  COEF_W  signed coefficient.
  hist_clr  in  1  clears the x/y history of all channels.
  busy  out  1  high in any state other than IDLE.

Function
REQ-003 The block SHALL compute y[n] = (sum over k=0..N of bk*x[n-k] - sum over k=1..N of ak*y[n-k]) >>> FRAC per channel, using one shared multiplier.
REQ-004 States: IDLE, MAC, OUT. IDLE goes to MAC on an accepted sample. MAC goes to OUT after 2*ORDER+1 product cycles. OUT goes to IDLE on out_valid && out_ready.
REQ-005 in_ready SHALL be 1 only in IDLE; a sample offered while busy stays pending and is not lost.
REQ-006 MAC SHALL take one term per cycle in order b0..bN, then a1..aN. out_valid rises exactly 2*ORDER+2 cycles after the accept edge.
REQ-007 The accumulator SHALL be DATA_W+COEF_W+clog2(2*ORDER+1) bits signed and SHALL not overflow internally. The final shift is arithmetic (floor).
REQ-008 out_valid, out_ch and out_data SHALL hold stable while out_valid && !out_ready.
REQ-009 Channel history (x[n-1..n-N], y[n-1..n-N]) SHALL update on the OUT-to-IDLE handshake only, storing the post-saturation or post-wrap y[n] as emitted.
REQ-010 coef_wr SHALL take effect only in IDLE; it is ignored in MAC or OUT. An out-of-range coef_addr is ignored.
REQ-011 A coefficient write and a sample accept on the same IDLE edge: the new coefficient SHALL apply to that sample.
REQ-012 hist_clr SHALL act only in IDLE. If it coincides with an accept, history is cleared before the sample is used, so the sample sees zero history.
REQ-013 An in_ch value of CHANNELS or above SHALL be accepted and discarded: no MAC run, no output, no history change.

Reset
REQ-014 With ARESETN=0 on a rising edge the block SHALL enter IDLE. out_valid=0, out_data=0, out_ch=0, busy=0, in_ready=1 from the first edge after release.
REQ-015 Reset SHALL clear all history and all coefficients to 0, including when asserted mid-MAC or mid-OUT. A result in flight is dropped.

Configuration
REQ-016 Macro DIFF_EQUATION_MC_SATURATE_EN:
  Defined: the shifted result clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  Undefined: the shifted result wraps (two's-complement truncation to DATA_W).

Verification (defaults: ORDER=2, CHANNELS=2, FRAC=14, 1.0=16384)
REQ-017 Release reset -> out_valid=0, out_data=0, busy=0, in_ready=1; all coefficients read back as producing y=0 for x=1000.
REQ-018 Set b0=16384, others 0; accept x=1000 on ch0 -> out_data=1000, out_ch=0, out_valid exactly 6 cycles after the accept.
REQ-019 Set b0=b1=16384; send ch0 x=100, ch0 x=200, ch1 x=50 -> outputs 100, 300, 50 (channels independent).
REQ-020 Set b0=16384, a1=-8192; send ch0 x=1000, then x=0 -> outputs 1000, 500. Assert hist_clr, then send x=0 -> output 0.
REQ-021 Set b0=32767; send x=30000 -> 32767 with SATURATE_EN defined, -5538 without.
REQ-022 Backpressure and reset:
  Hold out_ready=0 for 10 cycles -> out_data is stable, in_ready=0, a coef_wr in that window is ignored.
  Assert ARESETN=0 during MAC -> out_valid=0 next cycle, and the following b0-only sample shows no stale history.
